// File: rtl/sram_ctrl_pkg.sv
// Shared FSM state type, wait-counter width and block-index helper for the SRAM access controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    ACK,
    RELEASE,
    BERR
  } state_e;

  localparam int WAIT_CNT_W = 4;

  // Upper block_bits of an addr_w-wide word address, right-justified.
  function automatic int unsigned block_index(input logic [31:0] addr,
                                              input int unsigned addr_w,
                                              input int unsigned block_bits);
    logic [31:0] mask;
    mask = (32'd1 << block_bits) - 32'd1;
    return (addr >> (addr_w - block_bits)) & mask;
  endfunction

endpackage

// File: rtl/sram_block_decode.sv
// Combinational block decoder: index -> one-hot-low selects plus an in-range flag.
module sram_block_decode
  import sram_ctrl_pkg::*;
#(
  parameter int BLOCK_BITS = 2,
  parameter int NUM_BLOCKS = 4
) (
  input  logic [BLOCK_BITS-1:0] idx_i,
  input  logic                  valid_i,
  output logic [NUM_BLOCKS-1:0] block_l_o,
  output logic                  in_range_o
);

  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_sel
    assign block_l_o[gi] = ~(valid_i && (idx_i == BLOCK_BITS'(gi)));
  end

  assign in_range_o = (32'(idx_i) < 32'(NUM_BLOCKS));

endmodule

// File: rtl/sram_block_access_ctrl.sv
// SRAM block decoder and 68k access sequencer with registered selects, wait states and Dtack_L.
// Optional bus-error response for unpopulated blocks: define SRAM_BLOCK_BERR_EN.
module sram_block_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int BLOCK_BITS  = 2,
  parameter int NUM_BLOCKS  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic [ADDR_W-1:0]     Address,
  input  logic                  SRamSelect_H,
  input  logic                  AS_L,
  input  logic                  RW,
  input  logic                  UDS_L,
  input  logic                  LDS_L,
  output logic [NUM_BLOCKS-1:0] Block_L,
  output logic                  SRam_OE_L,
  output logic                  SRam_WE_L,
  output logic                  SRam_UB_L,
  output logic                  SRam_LB_L,
  output logic                  Dtack_L,
  output logic                  Busy_H
`ifdef SRAM_BLOCK_BERR_EN
  , output logic                Berr_L
`endif
);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0]   idx_q, idx_d, addr_idx, dec_idx;
  logic                    rw_q, rw_d, uds_q, uds_d, lds_q, lds_d;
  logic [NUM_BLOCKS-1:0]   block_l_q, block_l_d, dec_block_l;
  logic                    oe_l_q, oe_l_d, we_l_q, we_l_d;
  logic                    ub_l_q, ub_l_d, lb_l_q, lb_l_d;
  logic                    dtack_l_q, dtack_l_d, busy_q, busy_d;
  logic                    berr_l_q, berr_l_d;
  logic                    start, in_range, dec_valid, drive;

  assign start    = SRamSelect_H && !AS_L && (!UDS_L || !LDS_L);
  assign addr_idx = BLOCK_BITS'(block_index(32'(Address), ADDR_W, BLOCK_BITS));

  // While idle the decoder looks at the live address; afterwards at the latched index.
  assign dec_idx   = (state_q == IDLE) ? addr_idx : idx_q;
  assign dec_valid = (state_q == IDLE) ? start : 1'b1;

  sram_block_decode #(
    .BLOCK_BITS(BLOCK_BITS),
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_decode (
    .idx_i     (dec_idx),
    .valid_i   (dec_valid),
    .block_l_o (dec_block_l),
    .in_range_o(in_range)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = addr_idx;
          rw_d  = RW;
          uds_d = UDS_L;
          lds_d = LDS_L;
          cnt_d = WAIT_CNT_W'(WAIT_STATES);
          if (in_range) begin
            state_d = ACCESS;
          end
`ifdef SRAM_BLOCK_BERR_EN
          else begin
            state_d = BERR;
          end
`endif
        end
      end
      ACCESS: begin
        if (AS_L)              state_d = RELEASE;
        else if (cnt_q == '0)  state_d = ACK;
        else                   cnt_d   = cnt_q - WAIT_CNT_W'(1);
      end
      ACK:     if (AS_L) state_d = RELEASE;
      BERR:    if (AS_L) state_d = RELEASE;
      RELEASE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are a function of the next state so they appear registered on the same edge.
  always_comb begin
    drive     = (state_d == ACCESS) || (state_d == ACK);
    block_l_d = drive ? dec_block_l : '1;
    oe_l_d    = ~(drive && rw_d);
    we_l_d    = ~(drive && !rw_d);
    ub_l_d    = drive ? uds_d : 1'b1;
    lb_l_d    = drive ? lds_d : 1'b1;
    dtack_l_d = ~(state_d == ACK);
    busy_d    = (state_d != IDLE);
    berr_l_d  = ~(state_d == BERR);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      rw_q      <= 1'b1;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      block_l_q <= '1;
      oe_l_q    <= 1'b1;
      we_l_q    <= 1'b1;
      ub_l_q    <= 1'b1;
      lb_l_q    <= 1'b1;
      dtack_l_q <= 1'b1;
      busy_q    <= 1'b0;
      berr_l_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rw_q      <= rw_d;
      uds_q     <= uds_d;
      lds_q     <= lds_d;
      block_l_q <= block_l_d;
      oe_l_q    <= oe_l_d;
      we_l_q    <= we_l_d;
      ub_l_q    <= ub_l_d;
      lb_l_q    <= lb_l_d;
      dtack_l_q <= dtack_l_d;
      busy_q    <= busy_d;
      berr_l_q  <= berr_l_d;
    end
  end

  assign Block_L   = block_l_q;
  assign SRam_OE_L = oe_l_q;
  assign SRam_WE_L = we_l_q;
  assign SRam_UB_L = ub_l_q;
  assign SRam_LB_L = lb_l_q;
  assign Dtack_L   = dtack_l_q;
  assign Busy_H    = busy_q;
`ifdef SRAM_BLOCK_BERR_EN
  assign Berr_L    = berr_l_q;
`else
  logic unused_berr;
  assign unused_berr = berr_l_q;
`endif

endmodule

// File: tb/tb_sram_block_access_ctrl.sv
// Bench for sram_block_access_ctrl: three parameterisations on shared stimulus, table + directed + random.
module tb_sram_block_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l, sel, as_l, rw, uds_l, lds_l;
  logic [16:0] addr;

  wire [3:0] a_blk, b_blk;
  wire [2:0] c_blk;
  wire [2:0] oe, we, ub, lb, dt, busy;
`ifdef SRAM_BLOCK_BERR_EN
  wire [2:0] berr;
  localparam bit BERR_EN = 1'b1;
`else
  wire [2:0] berr = 3'b111;
  localparam bit BERR_EN = 1'b0;
`endif

  sram_block_access_ctrl #(.ADDR_W(17), .BLOCK_BITS(2), .NUM_BLOCKS(4), .WAIT_STATES(1)) dut_a (
    .Clock(clk), .Reset_L(rst_l), .Address(addr), .SRamSelect_H(sel), .AS_L(as_l), .RW(rw),
    .UDS_L(uds_l), .LDS_L(lds_l), .Block_L(a_blk), .SRam_OE_L(oe[0]), .SRam_WE_L(we[0]),
    .SRam_UB_L(ub[0]), .SRam_LB_L(lb[0]), .Dtack_L(dt[0]), .Busy_H(busy[0])
`ifdef SRAM_BLOCK_BERR_EN
    , .Berr_L(berr[0])
`endif
  );

  sram_block_access_ctrl #(.ADDR_W(17), .BLOCK_BITS(2), .NUM_BLOCKS(4), .WAIT_STATES(3)) dut_b (
    .Clock(clk), .Reset_L(rst_l), .Address(addr), .SRamSelect_H(sel), .AS_L(as_l), .RW(rw),
    .UDS_L(uds_l), .LDS_L(lds_l), .Block_L(b_blk), .SRam_OE_L(oe[1]), .SRam_WE_L(we[1]),
    .SRam_UB_L(ub[1]), .SRam_LB_L(lb[1]), .Dtack_L(dt[1]), .Busy_H(busy[1])
`ifdef SRAM_BLOCK_BERR_EN
    , .Berr_L(berr[1])
`endif
  );

  sram_block_access_ctrl #(.ADDR_W(17), .BLOCK_BITS(2), .NUM_BLOCKS(3), .WAIT_STATES(5)) dut_c (
    .Clock(clk), .Reset_L(rst_l), .Address(addr), .SRamSelect_H(sel), .AS_L(as_l), .RW(rw),
    .UDS_L(uds_l), .LDS_L(lds_l), .Block_L(c_blk), .SRam_OE_L(oe[2]), .SRam_WE_L(we[2]),
    .SRam_UB_L(ub[2]), .SRam_LB_L(lb[2]), .Dtack_L(dt[2]), .Busy_H(busy[2])
`ifdef SRAM_BLOCK_BERR_EN
    , .Berr_L(berr[2])
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: an access is "age" cycles old; selects while active, Dtack once age >= WS+2.
  int ws_m[3] = '{1, 3, 5};
  int nb_m[3] = '{4, 4, 3};
  bit act[3], rel[3], berr_m[3];
  int age[3], idx_m[3];
  bit rw_m[3], uds_m[3], lds_m[3];

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (!rst_l) begin
        act[i] = 0; rel[i] = 0; berr_m[i] = 0; age[i] = 0;
      end else if (rel[i]) begin
        rel[i] = 0;
      end else if (act[i] || berr_m[i]) begin
        if (as_l) begin
          act[i] = 0; berr_m[i] = 0; rel[i] = 1;
        end else begin
          age[i]++;
        end
      end else if (sel && !as_l && (!uds_l || !lds_l)) begin
        idx_m[i] = int'(addr[16:15]);
        rw_m[i] = rw; uds_m[i] = uds_l; lds_m[i] = lds_l;
        if (idx_m[i] < nb_m[i]) begin
          act[i] = 1; age[i] = 1;
        end else if (BERR_EN) begin
          berr_m[i] = 1;
        end
      end
    end
  endtask

  function automatic logic [10:0] exp_of(int i);
    logic [3:0] blk;
    logic [3:0] one;
    one = 4'b0001;
    blk = act[i] ? ~(one << idx_m[i]) : 4'hF;
    return {blk, ~(act[i] & rw_m[i]), ~(act[i] & ~rw_m[i]),
            act[i] ? uds_m[i] : 1'b1, act[i] ? lds_m[i] : 1'b1,
            ~(act[i] && age[i] >= ws_m[i] + 2), act[i] | rel[i] | berr_m[i], ~berr_m[i]};
  endfunction

  function automatic logic [10:0] got_of(int i);
    logic [3:0] blk;
    blk = (i == 0) ? a_blk : (i == 1) ? b_blk : {1'b1, c_blk};
    return {blk, oe[i], we[i], ub[i], lb[i], dt[i], busy[i], berr[i]};
  endfunction

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_of(i) !== exp_of(i)) begin
        failures++;
        $display("FAIL model_inst%0d t=%0t got=%b required=%b", i, $time, got_of(i), exp_of(i));
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic r, s, a, w, u, l, input logic [16:0] ad);
    rst_l = r; sel = s; as_l = a; rw = w; uds_l = u; lds_l = l; addr = ad;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  // Directed table for the WS=1, 4-block instance; exp = {Block_L, OE, WE, UB, LB, Dtack, Busy}.
  typedef struct {
    logic        r, s, a, w, u, l;
    logic [16:0] ad;
    logic [9:0]  exp;
  } vec_t;

  localparam logic [9:0] E_IDLE = {4'hF, 6'b111110};
  localparam logic [9:0] E_REL  = {4'hF, 6'b111111};
  vec_t vecs[24];

  initial begin
    int n;
    drive(0, 0, 1, 1, 1, 1, 17'h0);

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 17'h00000, E_IDLE};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 17'h00000, E_IDLE};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h08000, {4'hD, 6'b010011}};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h08000, {4'hD, 6'b010011}};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h08000, {4'hD, 6'b010001}};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h08000, {4'hD, 6'b010001}};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 17'h08000, E_REL};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 17'h00000, E_IDLE};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'h08000, E_IDLE};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'h08000, E_IDLE};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 17'h18002, {4'h7, 6'b100111}};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'h7, 6'b100111}};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'h7, 6'b100101}};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h18002, E_REL};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, E_IDLE};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'hE, 6'b011011}};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'hE, 6'b011011}};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'hE, 6'b011001}};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, E_IDLE};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'hE, 6'b011011}};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'hE, 6'b011011}};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, {4'hE, 6'b011001}};
    vecs[22] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 17'h00000, E_REL};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 17'h00000, E_IDLE};

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].w, vecs[i].u, vecs[i].l, vecs[i].ad);
      step();
      checks++;
      if (got_of(0)[10:1] !== vecs[i].exp) begin
        failures++;
        $display("FAIL table_row%0d got=%b required=%b", i, got_of(0)[10:1], vecs[i].exp);
      end
    end

    // WS=3 write, upper byte only: first Dtack_L low at N+5.
    drive(1, 1, 0, 0, 0, 1, 17'h18002);
    step();
    n = 1;
    while (dt[1] && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL ws3_dtack_latency got=%0d required=5", n);
    end
    check_bit("ws3_we", we[1], 1'b0);
    check_bit("ws3_ub", ub[1], 1'b0);
    check_bit("ws3_lb", lb[1], 1'b1);
    check_bit("ws3_blk3", b_blk[3], 1'b0);
    drive(1, 1, 1, 1, 1, 1, 17'h0);
    step();
    drive(1, 0, 1, 1, 1, 1, 17'h0);
    step();

    // Out-of-range block on the 3-block instance.
    drive(1, 1, 0, 1, 1, 0, 17'h18000);
    for (int k = 0; k < 3; k++) step();
    check_bit("oor_dtack", dt[2], 1'b1);
    check_bit("oor_noselect", &c_blk, 1'b1);
    check_bit("oor_busy", busy[2], BERR_EN);
    check_bit("oor_berr", berr[2], !BERR_EN);
    drive(1, 0, 1, 1, 1, 1, 17'h0);
    step();
    step();

    // Abort during ACCESS on the WS=5 instance.
    drive(1, 1, 0, 1, 0, 0, 17'h00000);
    step();
    step();
    drive(1, 1, 1, 1, 1, 1, 17'h00000);
    step();
    check_bit("abort_release_busy", busy[2], 1'b1);
    check_bit("abort_release_dtack", dt[2], 1'b1);
    check_bit("abort_release_oe", oe[2], 1'b1);
    step();
    check_bit("abort_idle_busy", busy[2], 1'b0);

    // Randomised traffic against the reference model.
    drive(1, 0, 1, 1, 1, 1, 17'h0);
    for (int k = 0; k < 3000; k++) begin
      rst_l = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 5) == 0) as_l = ~as_l;
      sel   = ($urandom_range(0, 4) != 0);
      rw    = 1'($urandom);
      uds_l = 1'($urandom);
      lds_l = 1'($urandom);
      addr  = 17'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_block_access_ctrl.md
Name: sram_block_access_ctrl

Overview:
Parametrised SRAM block decoder plus 68k bus access sequencer. It splits the SRAM word-address space into NUM_BLOCKS equal blocks and drives registered active-low block selects, OE/WE and byte lanes. It inserts a programmable number of wait states and returns Dtack_L to the 68k. It sits between the top-level address decoder (SRamSelect_H) and the SRAM chips, and replaces the purely combinational block decode.

Parameters:
ADDR_W, 17, word-address bits presented from the 68k bus
BLOCK_BITS, 2, upper address bits used as block index (Address[ADDR_W-1 -: BLOCK_BITS])
NUM_BLOCKS, 4, populated blocks; legal range 1..2**BLOCK_BITS
WAIT_STATES, 1, extra clocks between block select assertion and Dtack_L; legal range 0..15

Ports:
Clock  in  1  system clock; all state changes on rising edge
Reset_L  in  1  synchronous reset, active-low
Address  in  ADDR_W  68k address lines A[ADDR_W:1]
SRamSelect_H  in  1  top-level decode: cycle targets SRAM
AS_L  in  1  68k address strobe
RW  in  1  1 = read, 0 = write
UDS_L  in  1  upper data strobe
LDS_L  in  1  lower data strobe
Block_L  out  NUM_BLOCKS  one-hot-low block chip selects
SRam_OE_L  out  1  output enable (reads)
SRam_WE_L  out  1  write enable (writes)
SRam_UB_L  out  1  upper byte lane enable
SRam_LB_L  out  1  lower byte lane enable
Dtack_L  out  1  data acknowledge to 68k
Busy_H  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (Reset_L low at a rising edge): FSM = IDLE, wait counter = 0, all *_L outputs = 1, Busy_H = 0. Reset wins over every other event, including mid-access.
- All outputs are registered; no combinational path from inputs to outputs.
- Start condition, sampled in IDLE: SRamSelect_H=1, AS_L=0 and (UDS_L=0 or LDS_L=0). On a start, latch block index, RW, UDS_L and LDS_L.
- Index >= NUM_BLOCKS: no select is asserted and the FSM stays IDLE. The cycle is left to the system bus timeout (see feature).
- States:
  - IDLE: on a valid start, go to ACCESS (cycle N). Load counter with WAIT_STATES.
  - ACCESS (from N+1): Block_L[idx]=0. SRam_UB_L/LB_L = latched UDS_L/LDS_L. Read: SRam_OE_L=0. Write: SRam_WE_L=0. Counter decrements each cycle. When counter = 0, go to ACK.
  - ACK: keep ACCESS outputs and drive Dtack_L=0. Stay while AS_L=0. When AS_L=1, go to RELEASE.
  - RELEASE: all outputs return to 1 for exactly one cycle, then go to IDLE. A new start is not accepted in RELEASE.
- Latency: Dtack_L first low at cycle N+2+WAIT_STATES. With WAIT_STATES=0, ACCESS lasts one cycle.
- Abort: AS_L=1 in ACCESS goes directly to RELEASE; Dtack_L is never asserted.
- Input changes (Address/RW/strobes) after the start are ignored until IDLE.
- Block select is exactly one-hot-low or all ones, never two low.
- SRam_OE_L and SRam_WE_L are never both 0.

Optional Feature:
Macro SRAM_BLOCK_BERR_EN.
- Defined: adds output Berr_L (1 bit, reset 1). A start whose index >= NUM_BLOCKS enters state BERR: Berr_L=0, no selects, Dtack_L=1. BERR holds until AS_L=1, then goes through RELEASE to IDLE.
- Undefined: no Berr_L port; out-of-range cycles are ignored as above.

Decomposition:
- Package sram_ctrl_pkg holds:
  - FSM state enum: IDLE, ACCESS, ACK, RELEASE, BERR
  - WAIT_CNT_W = 4
  - localparam function for block-index extraction
- One natural sub-module: sram_block_decode. It is combinational: index plus valid in, one-hot-low Block_L and in_range out. It is instantiated once and its outputs are registered in the parent.

Test Plan:
- Defaults, read at Address=17'h0_8000, AS_L/LDS_L/UDS_L low -> Block_L=4'b1101 and SRam_OE_L=0 from N+1; Dtack_L=0 at N+3; all ones one cycle after AS_L rises.
- WAIT_STATES=3, write to Address=17'h1_8002, UDS_L only -> Block_L=4'b0111, SRam_WE_L=0, SRam_UB_L=0, SRam_LB_L=1; Dtack_L low at N+5.
- NUM_BLOCKS=3, access at Address=17'h1_8000 -> no select and no Dtack_L. With SRAM_BLOCK_BERR_EN: Berr_L=0 from N+1 until AS_L rises.
- AS_L rises during ACCESS with WAIT_STATES=5 -> RELEASE next cycle, Dtack_L stays 1, then IDLE.
- Reset_L=0 during ACK -> next edge: all outputs 1, Busy_H=0. A subsequent access completes normally.
- SRamSelect_H=0 with AS_L=0 -> FSM stays IDLE, all outputs 1. Also check back-to-back accesses are separated by at least one RELEASE cycle.
